fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised multi-cycle fetch/PC sequencer for the RISC-V processor. It replaces the hard-wired 4-cycle PC counter of the current datapath. It issues instruction-memory requests with a req/ack handshake, holds the instruction register, and sequences a configurable number of execute phases. At retire it updates the PC: sequentially, by a relative branch, or to an absolute jump target, with a misalignment trap.

Parameters:
WORDSIZE, 64, PC and offset width
INSTRUCTION_SIZE, 32, instruction width
i_addr_bits, 6, instruction-memory word-address width
PC_STEP, 4, bytes per instruction; power of two, at least 1
MIN_PHASES, 4, cycles per instruction with zero-wait memory; range 2..8
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset
stall  in  1  hold instruction in its last execute phase
redirect_en  in  1  take redirect at retire
redirect_abs  in  1  1: absolute target (JALR); 0: PC-relative (branch/JAL)
redirect_value  in  WORDSIZE  target or signed offset, pre-sign-extended by the decoder
i_mem_req  out  1  fetch request
i_mem_addr  out  i_addr_bits  word address, equal to pc[log2(PC_STEP)+i_addr_bits-1 : log2(PC_STEP)]
i_mem_ack  in  1  data valid on i_mem_data
i_mem_data  in  INSTRUCTION_SIZE  fetched instruction
instr  out  INSTRUCTION_SIZE  instruction register
instr_valid  out  1  instr holds the current instruction (EXEC state)
pc  out  WORDSIZE  address of the current instruction
phase  out  3  0 in FETCH; 1..MIN_PHASES-1 in EXEC
retire  out  1  one-cycle pulse when the PC advances
misaligned  out  1  sticky trap flag

Behaviour:
- Reset is asynchronous and active-low; one clock. On reset:
  - state=FETCH, pc=RESET_PC, instr=0, phase=0
  - instr_valid=0, retire=0, misaligned=0
  - i_mem_req=1 from the first cycle after release.
- States: FETCH, EXEC, HALT.
- FETCH:
  - i_mem_req=1.
  - On a clk edge with i_mem_ack=1: instr<=i_mem_data, phase<=1, go to EXEC.
  - Otherwise wait indefinitely; pc, instr and phase are held.
  - Ack is sampled only in FETCH; ack in other states is ignored.
- EXEC:
  - i_mem_req=0, instr_valid=1, instr is stable.
  - phase increments each cycle.
  - At phase==MIN_PHASES-1 with stall=1: hold; no retire.
  - At phase==MIN_PHASES-1 with stall=0: retire=1 that cycle (combinational). On the edge, pc<=pc_next, phase<=0, go to FETCH.
  - stall is ignored in earlier phases.
- pc_next:
  - redirect_en=0: pc+PC_STEP.
  - redirect_en=1, redirect_abs=0: pc+redirect_value.
  - redirect_en=1, redirect_abs=1: redirect_value.
  - All arithmetic is modulo 2^WORDSIZE; pc wraps silently.
  - i_mem_addr truncates, so fetches wrap within instruction memory.
- Redirect inputs are sampled only in the retiring cycle; other cycles ignore them.
- Misalignment: if pc_next[log2(PC_STEP)-1:0]!=0 at retire:
  - pc<=pc_next (recorded for debug), misaligned<=1, go to HALT, retire still pulses.
  - The check does not apply when PC_STEP=1.
- HALT: i_mem_req=0, instr_valid=0. Exit only by reset.
- With zero-wait memory (ack tied high), CPI = MIN_PHASES. Each cycle of ack delay adds one cycle.
- Reset asserted mid-fetch or mid-exec aborts immediately. A pending ack is discarded.

Decomposition:
- Package fetch_pkg:
  - state enum (FETCH=2'd0, EXEC=2'd1, HALT=2'd2)
  - localparam helpers: PC_STEP_LOG2, PHASE_LAST=MIN_PHASES-1.
- One sub-module, pc_next_calc: combinational pc_next and misalignment-check block. It is parametrised by WORDSIZE and PC_STEP and is reusable by a future pipelined core.
- The FSM, phase counter and registers stay in fetch_unit.

Test Plan:
1. Sequential, zero wait: reset, ack tied 1, MIN_PHASES=4, stall=0, no redirects -> retire every 4 cycles; pc=0,4,8,12; i_mem_addr=0,1,2,3; instr matches memory words.
2. Wait states: ack asserted 2 cycles after req -> 6-cycle CPI; instr changes only on the ack edge; phase=0 throughout the wait.
3. Relative redirect at pc=16 with redirect_value=-8 -> next pc=8. Absolute redirect with value 0x40 -> pc=0x40, i_mem_addr=16. Redirect asserted in phase 1 only -> ignored, pc+4.
4. Stall held 5 cycles at phase 3 -> no retire, pc and instr stable. Release -> retire in the same cycle, FETCH next.
5. Absolute redirect to 0x42 -> misaligned=1, pc=0x42, HALT, i_mem_req=0 forever. rst_n pulsed low mid-cycle -> outputs clear asynchronously, pc=RESET_PC.
6. Wrap: absolute redirect to 2^64-4, then sequential retire -> pc=0, i_mem_addr=0, no trap.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the multi-cycle fetch/PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam int PC_STEP_DEFAULT    = 4;
  localparam int MIN_PHASES_DEFAULT = 4;
  localparam int PC_STEP_LOG2       = $clog2(PC_STEP_DEFAULT);
  localparam int PHASE_LAST         = MIN_PHASES_DEFAULT - 1;

  // Parameter-dependent forms for modules that override the defaults
  function automatic int pc_step_log2(input int step);
    return $clog2(step);
  endfunction

  function automatic int phase_last(input int min_phases);
    return min_phases - 1;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection (sequential / relative / absolute) and alignment check.
import fetch_pkg::*;

module pc_next_calc #(
  parameter int WORDSIZE = 64,
  parameter int PC_STEP  = 4
) (
  input  logic [WORDSIZE-1:0] pc,
  input  logic                redirect_en,
  input  logic                redirect_abs,
  input  logic [WORDSIZE-1:0] redirect_value,
  output logic [WORDSIZE-1:0] pc_next,
  output logic                misaligned
);

  localparam int STEP_LOG2 = pc_step_log2(PC_STEP);

  always_comb begin
    pc_next = pc + WORDSIZE'(PC_STEP);
    if (redirect_en) begin
      if (redirect_abs) pc_next = redirect_value;
      else              pc_next = pc + redirect_value;
    end
  end

  // A byte-granular step has no alignment constraint
  generate
    if (STEP_LOG2 == 0) begin : g_no_check
      assign misaligned = 1'b0;
    end else begin : g_check
      assign misaligned = |pc_next[STEP_LOG2-1:0];
    end
  endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch/PC sequencer: req/ack fetch, N execute phases, PC update at retire.
import fetch_pkg::*;

module fetch_unit #(
  parameter int              WORDSIZE         = 64,
  parameter int              INSTRUCTION_SIZE = 32,
  parameter int              i_addr_bits      = 6,
  parameter int              PC_STEP          = 4,
  parameter int              MIN_PHASES       = 4,
  parameter logic [WORDSIZE-1:0] RESET_PC     = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        redirect_en,
  input  logic                        redirect_abs,
  input  logic [WORDSIZE-1:0]         redirect_value,
  output logic                        i_mem_req,
  output logic [i_addr_bits-1:0]      i_mem_addr,
  input  logic                        i_mem_ack,
  input  logic [INSTRUCTION_SIZE-1:0] i_mem_data,
  output logic [INSTRUCTION_SIZE-1:0] instr,
  output logic                        instr_valid,
  output logic [WORDSIZE-1:0]         pc,
  output logic [2:0]                  phase,
  output logic                        retire,
  output logic                        misaligned
);

  localparam int         STEP_LOG2 = pc_step_log2(PC_STEP);
  localparam logic [2:0] LAST_PH   = 3'(phase_last(MIN_PHASES));

  fetch_state_t                state_reg, state_next;
  logic [WORDSIZE-1:0]         pc_reg, pc_next;
  logic [INSTRUCTION_SIZE-1:0] instr_reg, instr_next;
  logic [2:0]                  phase_reg, phase_next;
  logic                        mis_reg, mis_next;
  logic [WORDSIZE-1:0]         pc_calc;
  logic                        pc_calc_mis;

  pc_next_calc #(
    .WORDSIZE (WORDSIZE),
    .PC_STEP  (PC_STEP)
  ) u_pc_next_calc (
    .pc             (pc_reg),
    .redirect_en    (redirect_en),
    .redirect_abs   (redirect_abs),
    .redirect_value (redirect_value),
    .pc_next        (pc_calc),
    .misaligned     (pc_calc_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      phase_reg <= '0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      phase_reg <= phase_next;
      mis_reg   <= mis_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    phase_next = phase_reg;
    mis_next   = mis_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH: begin
        if (i_mem_ack) begin
          instr_next = i_mem_data;
          phase_next = 3'd1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (phase_reg == LAST_PH) begin
          if (!stall) begin
            retire     = 1'b1;
            pc_next    = pc_calc;
            phase_next = 3'd0;
            // The faulting target is still latched into pc for debug
            if (pc_calc_mis) begin
              mis_next   = 1'b1;
              state_next = HALT;
            end else begin
              state_next = FETCH;
            end
          end
        end else begin
          phase_next = phase_reg + 3'd1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign i_mem_req   = (state_reg == FETCH);
  assign instr_valid = (state_reg == EXEC);
  assign i_mem_addr  = pc_reg[STEP_LOG2+i_addr_bits-1:STEP_LOG2];
  assign instr       = instr_reg;
  assign pc          = pc_reg;
  assign phase       = phase_reg;
  assign misaligned  = mis_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed instruction vectors, retire monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic        redirect_abs = 1'b0;
  logic [63:0] redirect_value = '0;
  logic        i_mem_req, i_mem_ack;
  logic [5:0]  i_mem_addr;
  logic [31:0] i_mem_data, instr;
  logic        instr_valid;
  logic [63:0] pc;
  logic [2:0]  phase;
  logic        retire, misaligned;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int last_ret = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    int          cpi;
  } exp_t;
  exp_t sb[$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_en    (redirect_en),
    .redirect_abs   (redirect_abs),
    .redirect_value (redirect_value),
    .i_mem_req      (i_mem_req),
    .i_mem_addr     (i_mem_addr),
    .i_mem_ack      (i_mem_ack),
    .i_mem_data     (i_mem_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .phase          (phase),
    .retire         (retire),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return 32'h1357_0000 + 32'(a);
  endfunction

  assign i_mem_data = mem_word(i_mem_addr);
  assign i_mem_ack  = i_mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_mem_req && !i_mem_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Retire monitor: every retire pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && retire) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: got pc %h expected no retire", pc);
      end else begin
        e = sb.pop_front();
        check("retire_pc", pc, e.pc);
        check("retire_instr", 64'(instr), 64'(e.instr));
        check("retire_addr", 64'(i_mem_addr), 64'(e.pc[7:2]));
        if (e.cpi != 0) check("cpi", 64'(cyc - last_ret), 64'(e.cpi));
        $display("retire pc=%h instr=%h addr=%0d cycles=%0d", pc, instr, i_mem_addr, cyc - last_ret);
      end
      last_ret = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction: fetch (with ack delay), optional redirect in phase rph, optional stall
  task automatic run_instr(input int delay, input logic en, input logic abs,
                           input logic [63:0] val, input int rph, input int stall_cyc,
                           input logic [63:0] exp_pc, input logic [63:0] exp_next,
                           input int cpi);
    int n;
    logic [31:0] prev_instr;
    ack_delay = delay;
    sb.push_back('{exp_pc, mem_word(exp_pc[7:2]), cpi});
    prev_instr = instr;
    n = 0;
    while (!instr_valid && n < 50) begin
      check("fetch_phase", 64'(phase), 64'd0);
      check("fetch_instr_hold", 64'(instr), 64'(prev_instr));
      step();
      n++;
    end
    check("exec_pc", pc, exp_pc);
    check("exec_instr", 64'(instr), 64'(mem_word(exp_pc[7:2])));
    while (32'(phase) != rph && n < 50) begin
      step();
      n++;
    end
    redirect_en = en;
    redirect_abs = abs;
    redirect_value = val;
    if (rph != 3) begin
      step();
      redirect_en = 1'b0;
      redirect_value = '0;
      while (phase != 3'd3 && n < 50) begin
        step();
        n++;
      end
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles expected under 50", n);
      return;
    end
    if (stall_cyc > 0) begin
      stall = 1'b1;
      repeat (stall_cyc) begin
        step();
        check("stall_no_retire", 64'(retire), 64'd0);
        check("stall_phase", 64'(phase), 64'd3);
        check("stall_pc", pc, exp_pc);
        check("stall_instr", 64'(instr), 64'(mem_word(exp_pc[7:2])));
      end
      stall = 1'b0;
      #1;
      check("stall_release_retire", 64'(retire), 64'd1);
    end
    step();
    redirect_en = 1'b0;
    redirect_abs = 1'b0;
    redirect_value = '0;
    check("next_pc", pc, exp_next);
    check("next_addr", 64'(i_mem_addr), 64'(exp_next[7:2]));
    check("next_phase", 64'(phase), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_mis", 64'(misaligned), 64'd0);
    rst_n = 1'b1;
    #1;
    check("req_after_release", 64'(i_mem_req), 64'd1);

    // Sequential, zero wait
    run_instr(0, 0, 0, 64'd0, 3, 0, 64'h00, 64'h04, 0);
    run_instr(0, 0, 0, 64'd0, 3, 0, 64'h04, 64'h08, 4);
    run_instr(0, 0, 0, 64'd0, 3, 0, 64'h08, 64'h0C, 4);
    run_instr(0, 0, 0, 64'd0, 3, 0, 64'h0C, 64'h10, 4);
    // Redirects
    run_instr(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 3, 0, 64'h10, 64'h08, 4);
    run_instr(0, 1, 1, 64'h40, 3, 0, 64'h08, 64'h40, 4);
    run_instr(0, 1, 1, 64'h100, 1, 0, 64'h40, 64'h44, 4);
    // Two wait states
    run_instr(2, 0, 0, 64'd0, 3, 0, 64'h44, 64'h48, 6);
    run_instr(2, 0, 0, 64'd0, 3, 0, 64'h48, 64'h4C, 6);
    // Stall in last phase
    run_instr(0, 0, 0, 64'd0, 3, 5, 64'h4C, 64'h50, 9);
    // Misaligned absolute target
    run_instr(0, 1, 1, 64'h42, 3, 0, 64'h50, 64'h42, 4);
    check("trap_mis", 64'(misaligned), 64'd1);
    repeat (5) begin
      step();
      check("halt_req", 64'(i_mem_req), 64'd0);
      check("halt_valid", 64'(instr_valid), 64'd0);
      check("halt_retire", 64'(retire), 64'd0);
      check("halt_pc", pc, 64'h42);
    end
    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 64'd0);
    check("arst_mis", 64'(misaligned), 64'd0);
    check("arst_instr", 64'(instr), 64'd0);
    check("arst_phase", 64'(phase), 64'd0);
    check("arst_valid", 64'(instr_valid), 64'd0);
    step();
    rst_n = 1'b1;
    // Wrap at top of address space
    run_instr(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 3, 0, 64'h00, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    run_instr(0, 0, 0, 64'd0, 3, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h00, 4);
    check("wrap_mis", 64'(misaligned), 64'd0);
    run_instr(0, 0, 0, 64'd0, 3, 0, 64'h00, 64'h04, 4);

    repeat (2) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
